// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants: default baud generator widths, oversampling ratio
// and the divisor loaded at reset. The RX/TX oversampling FSMs import the
// same values so they agree with the tick generator on OSR.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Integer and fractional divisor widths.
  localparam int BAUD_N   = 16;
  localparam int BAUD_F   = 4;

  // Oversampling ratio (power of two, >= 2).
  localparam int BAUD_OSR = 16;

  // Divisor active straight out of reset.
  localparam int BAUD_DIV_INIT_INT  = 65;
  localparam int BAUD_DIV_INIT_FRAC = 0;

  // Divisors below two would give back-to-back ticks; clamp them.
  localparam int BAUD_DIV_MIN = 2;

endpackage : uart_pkg

// File: rtl/baud_frac_acc.sv
// -----------------------------------------------------------------------------
// baud_frac_acc
// Fractional phase accumulator for the baud tick generator. At every period
// boundary the fractional divisor is added to the accumulator; the carry out
// becomes o_ext, which lengthens the following period by one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   i_clr      in   clear accumulator and carry (phase restart / new divisor)
//   i_acc_en   in   period boundary: accumulate i_frac
//   i_frac     in   active fractional divisor [F]
//   o_ext      out  extend the current period by one cycle
// -----------------------------------------------------------------------------
module baud_frac_acc #(
  parameter int F = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_acc_en,
  input  logic [F-1:0] i_frac,
  output logic         o_ext
);

  logic [F-1:0] r_frac_acc;
  logic         r_ext;
  logic [F:0]   w_sum;

  assign w_sum = {1'b0, r_frac_acc} + {1'b0, i_frac};

  // Clear wins over accumulate so a newly applied divisor starts from a
  // clean phase even when it lands on a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frac_acc <= '0;
      r_ext      <= 1'b0;
    end else if (i_clr) begin
      r_frac_acc <= '0;
      r_ext      <= 1'b0;
    end else if (i_acc_en) begin
      {r_ext, r_frac_acc} <= w_sum;
    end
  end

  assign o_ext = r_ext;

endmodule : baud_frac_acc

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Programmable fractional baud-rate tick generator. Divides clk by
// div_int + div_frac/2^F (average), emitting s_tick once per period and
// bit_tick on every OSR-th s_tick.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   counting enable
//   sync_clr   in   phase restart (RX start-bit alignment), beats en and tick
//   div_int    in   requested integer divisor [N]
//   div_frac   in   requested fractional divisor [F]
//   div_load   in   one-cycle pulse capturing div_int/div_frac into shadow
//   div_busy   out  a shadow divisor is pending
//   s_tick     out  one-cycle oversampling tick
//   bit_tick   out  one-cycle bit tick (every OSR-th s_tick)
//
// Load protocol: div_load is a fire-and-forget pulse (no ready). The value
// goes into a shadow register and div_busy rises the next cycle. The shadow
// is copied to the active divisor at the next period boundary, sync_clr or
// any idle (en=0) edge; div_busy falls the cycle after. A load while busy
// overwrites the shadow; a load on the applying edge waits for the next one.
// -----------------------------------------------------------------------------
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int N             = BAUD_N,
  parameter int F             = BAUD_F,
  parameter int OSR           = BAUD_OSR,
  parameter int DIV_INIT_INT  = BAUD_DIV_INIT_INT,
  parameter int DIV_INIT_FRAC = BAUD_DIV_INIT_FRAC
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         sync_clr,
  input  logic [N-1:0] div_int,
  input  logic [F-1:0] div_frac,
  input  logic         div_load,
  output logic         div_busy,
  output logic         s_tick,
  output logic         bit_tick
);

  localparam int             OSW       = $clog2(OSR);
  localparam logic [N-1:0]   INIT_INT  = N'(DIV_INIT_INT);
  localparam logic [F-1:0]   INIT_FRAC = F'(DIV_INIT_FRAC);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OSR - 1);
  localparam logic [N:0]     LEN_MIN   = (N+1)'(BAUD_DIV_MIN);

  logic [N-1:0]   r_cnt;
  logic [OSW-1:0] r_os_cnt;
  logic [N-1:0]   r_act_int;
  logic [F-1:0]   r_act_frac;
  logic [N-1:0]   r_sh_int;
  logic [F-1:0]   r_sh_frac;
  logic           r_pending;

  logic           w_ext;
  logic [N:0]     w_base;
  logic [N:0]     w_len;
  logic [N:0]     w_last;
  logic           w_at_end;
  logic           w_apply;

  // Period length: clamped integer divisor plus the fractional carry.
  // One extra bit so the largest divisor plus carry cannot overflow.
  assign w_base   = ({1'b0, r_act_int} < LEN_MIN) ? LEN_MIN : {1'b0, r_act_int};
  assign w_len    = w_base + {{N{1'b0}}, w_ext};
  assign w_last   = w_len - (N+1)'(1);
  assign w_at_end = ({1'b0, r_cnt} == w_last);

  assign s_tick   = en & ~sync_clr & w_at_end;
  assign bit_tick = s_tick & (r_os_cnt == OS_LAST);
  assign div_busy = r_pending;

  // The shadow may only be applied when no period is in flight: at a
  // boundary, on a phase restart, or while counting is frozen.
  assign w_apply  = r_pending & (sync_clr | ~en | s_tick);

  // Period and oversample counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else if (sync_clr) begin
      r_cnt    <= '0;
      r_os_cnt <= '0;
    end else if (en) begin
      if (s_tick) begin
        r_cnt    <= '0;
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Active/shadow divisor registers. The active copy takes the shadow value
  // held before this edge, so a load on the applying edge stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_int  <= INIT_INT;
      r_act_frac <= INIT_FRAC;
      r_sh_int   <= INIT_INT;
      r_sh_frac  <= INIT_FRAC;
      r_pending  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      if (div_load) begin
        r_sh_int  <= div_int;
        r_sh_frac <= div_frac;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // A new divisor or a phase restart discards the accumulated fraction.
  baud_frac_acc #(
    .F        (F)
  ) u_frac_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (sync_clr | w_apply),
    .i_acc_en (s_tick),
    .i_frac   (r_act_frac),
    .o_ext    (w_ext)
  );

endmodule : baud_tick_gen
